// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and parameter helpers for the cache fill controller
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fill_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int bpw(input int data_w);
        return data_w / 8;
    endfunction

    // Byte-offset bits inside one block: word index bits plus byte-in-word bits.
    function automatic int off_w(input int words_per_block, input int data_w);
        return clog2(words_per_block) + clog2(bpw(data_w));
    endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// rtl/fixed_prio_arb.sv - combinational fixed-priority arbiter, lowest index wins
module fixed_prio_arb
    import cache_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt
);

    // Two's complement isolates the lowest set bit.
    assign gnt = req & (~req + NUM_CH'(1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - block fill engine: arbitrates cache misses and streams
// a block from fixed-latency memory into the granted cache's data and tag arrays
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int NUM_CH          = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        miss_req,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
    output logic [NUM_CH-1:0]        grant,
    output logic                     busy,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_rd_valid,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic [NUM_CH-1:0]        fill_we,
    output logic [ADDR_W-1:0]        fill_addr,
    output logic [DATA_W-1:0]        fill_data,
    output logic [NUM_CH-1:0]        tag_we,
    output logic [NUM_CH-1:0]        miss_done
);

    localparam int BPW   = bpw(DATA_W);
    localparam int OFF_W = off_w(WORDS_PER_BLOCK, DATA_W);
    localparam int CNT_W = clog2(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

    if (!is_pow2(WORDS_PER_BLOCK) || WORDS_PER_BLOCK < 2) begin : g_bad_words
        $error("WORDS_PER_BLOCK must be a power of two and at least 2");
    end
    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("MEM_LATENCY must be at least 1");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(idx) * ADDR_W'(BPW);
    endfunction

    fill_state_t         state_q, state_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic                busy_q;
    logic                mem_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   fill_addr_q;
    logic [NUM_CH-1:0]   miss_done_q;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic                ret_fire;
    logic                last_ret;

    fixed_prio_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req (miss_req),
        .gnt (arb_gnt)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Returns only count while a fill is outstanding; anything seen in IDLE/DONE is stale.
    assign ret_fire = mem_rd_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN);
    assign last_ret = ret_fire && (ret_cnt_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        base_d      = base_q;
        grant_d     = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|miss_req) begin
                    state_d     = ST_ISSUE;
                    grant_d     = arb_gnt;
                    base_d      = sel_addr & BASE_MASK;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
                if (issue_cnt_q == LAST_IDX) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        if (ret_fire) ret_cnt_d = ret_cnt_q + CNT_W'(1);
        if (last_ret) state_d = ST_DONE;
    end

    // Registered outputs are computed from next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            fill_addr_q <= '0;
            miss_done_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_q      <= base_d;
            grant_q     <= grant_d;
            busy_q      <= (state_d != ST_IDLE);
            mem_en_q    <= (state_d == ST_ISSUE);
            mem_addr_q  <= word_addr(base_d, issue_cnt_d);
            fill_addr_q <= word_addr(base_d, ret_cnt_d);
            miss_done_q <= (state_d == ST_DONE) ? grant_d : '0;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign fill_addr = fill_addr_q;
    assign fill_data = mem_rd_data;
    assign fill_we   = ret_fire ? grant_q : '0;
    assign tag_we    = last_ret ? grant_q : '0;
    assign miss_done = miss_done_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - self-checking bench for cache_fill_ctrl
module tb_cache_fill_ctrl;

    localparam int AW = 16, DW = 16, W = 8, L = 4, NCH = 2, BPW = 2;
    localparam int DW2 = 32, W2 = 4, L2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NCH-1:0]    miss_req = '0;
    logic [NCH*AW-1:0] miss_addr = '0;
    logic [NCH-1:0]    grant, fill_we, tag_we, miss_done;
    logic              busy, mem_en;
    logic [AW-1:0]     mem_addr, fill_addr;
    logic              mem_rd_valid = 1'b0;
    logic [DW-1:0]     mem_rd_data = '0;
    logic [DW-1:0]     fill_data;

    logic              req2 = 1'b0;
    logic [AW-1:0]     addr2 = '0;
    logic              grant2, busy2, mem_en2, fill_we2, tag_we2, miss_done2;
    logic [AW-1:0]     mem_addr2, fill_addr2;
    logic              mrv2 = 1'b0;
    logic [DW2-1:0]    mrd2 = '0;
    logic [DW2-1:0]    fill_data2;

    cache_fill_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(W), .MEM_LATENCY(L), .NUM_CH(NCH)
    ) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .grant(grant), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .tag_we(tag_we), .miss_done(miss_done)
    );

    cache_fill_ctrl #(
        .ADDR_W(AW), .DATA_W(DW2), .WORDS_PER_BLOCK(W2), .MEM_LATENCY(L2), .NUM_CH(1)
    ) dut2 (
        .clk(clk), .rst(rst), .miss_req(req2), .miss_addr(addr2),
        .grant(grant2), .busy(busy2), .mem_en(mem_en2), .mem_addr(mem_addr2),
        .mem_rd_valid(mrv2), .mem_rd_data(mrd2),
        .fill_we(fill_we2), .fill_addr(fill_addr2), .fill_data(fill_data2),
        .tag_we(tag_we2), .miss_done(miss_done2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 0;
    bit glitch_en = 0;
    logic [NCH-1:0] last_done = '0;

    // Reference model: fill age m_t counts cycles since the accepting edge.
    bit         m_active = 0;
    int         m_t = 0;
    int         m_ch = 0;
    logic [AW-1:0] m_base = '0;

    bit         pend_v[64];
    logic [AW-1:0] pend_a[64];
    bit         p2_v = 0;
    logic [AW-1:0] p2_a = '0;

    int ev_issue_c[$];
    logic [AW-1:0] ev_issue_a[$];
    int ev_fill_c[$];
    int ev_tag_c[$];
    int ev_done_c[$];
    int ev_done_ch[$];
    logic [AW-1:0] ev2_issue_a[$];
    logic [AW-1:0] ev2_fill_a[$];
    int ev2_tag_c[$];
    int ev2_done_c[$];

    function automatic logic [DW-1:0] dfn(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 0;
            m_t = 0;
        end else if (m_active) begin
            if (m_t == W + L + 1) m_active = 0;
            else m_t++;
        end else if (miss_req != '0) begin
            m_ch = miss_req[0] ? 0 : 1;
            m_base = miss_addr[m_ch*AW +: AW] & ~AW'(W * BPW - 1);
            m_active = 1;
            m_t = 1;
        end
    end

    // Memory models: fixed latency, returning data derived from the address.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        mem_rd_valid = pend_v[cyc % 64];
        mem_rd_data = pend_v[cyc % 64] ? dfn(pend_a[cyc % 64]) : '0;
        pend_v[cyc % 64] = 0;
        if (glitch_en && !m_active && $urandom_range(0, 2) == 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data = DW'($urandom);
        end
        mrv2 = p2_v;
        mrd2 = {p2_a, ~p2_a};
        p2_v = 0;
    end

    initial forever begin
        logic [NCH-1:0] exp_oh;
        bit issuing, filling;
        logic [AW-1:0] exp_fa;
        @(negedge clk);
        if (mem_en) begin
            pend_v[(cyc + L) % 64] = 1;
            pend_a[(cyc + L) % 64] = mem_addr;
            ev_issue_c.push_back(cyc);
            ev_issue_a.push_back(mem_addr);
        end
        if (fill_we != '0) ev_fill_c.push_back(cyc);
        if (tag_we != '0) ev_tag_c.push_back(cyc);
        if (miss_done != '0) begin
            ev_done_c.push_back(cyc);
            ev_done_ch.push_back(miss_done[0] ? 0 : 1);
        end
        last_done = miss_done;
        p2_v = mem_en2;
        p2_a = mem_addr2;
        if (mem_en2) ev2_issue_a.push_back(mem_addr2);
        if (fill_we2) begin
            ev2_fill_a.push_back(fill_addr2);
            chk("fill2_data", fill_data2, {fill_addr2, ~fill_addr2});
        end
        if (tag_we2) ev2_tag_c.push_back(cyc);
        if (miss_done2) ev2_done_c.push_back(cyc);

        if (cmp_en) begin
            exp_oh  = m_active ? NCH'(1 << m_ch) : '0;
            issuing = m_active && (m_t <= W);
            filling = m_active && (m_t >= L + 1) && (m_t <= W + L);
            exp_fa  = m_base + AW'((m_t - L - 1) * BPW);
            chk("busy", busy, m_active);
            chk("grant", grant, exp_oh);
            chk("mem_en", mem_en, issuing);
            if (issuing) chk("mem_addr", mem_addr, m_base + AW'((m_t - 1) * BPW));
            chk("fill_we", fill_we, filling ? exp_oh : '0);
            if (filling) begin
                chk("fill_addr", fill_addr, exp_fa);
                chk("fill_data", fill_data, dfn(exp_fa));
            end
            chk("tag_we", tag_we, (m_active && m_t == W + L) ? exp_oh : '0);
            chk("miss_done", miss_done, (m_active && m_t == W + L + 1) ? exp_oh : '0);
        end
    end

    task automatic clear_logs();
        ev_issue_c.delete(); ev_issue_a.delete(); ev_fill_c.delete(); ev_tag_c.delete();
        ev_done_c.delete(); ev_done_ch.delete();
        ev2_issue_a.delete(); ev2_fill_a.delete(); ev2_tag_c.delete(); ev2_done_c.delete();
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic wait_done(input int count, input int limit);
        int n;
        n = 0;
        while (ev_done_c.size() < count && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_wait", 32'(ev_done_c.size() >= count), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0, n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_grant", grant, 2'b00);
        settle();

        // Single default fill
        c0 = cyc;
        miss_addr[15:0] = 16'h1236;
        miss_req = 2'b01;
        wait_done(1, 40);
        miss_req = 2'b00;
        chk("t1_done_cycle", ev_done_c.size() > 0 ? ev_done_c[0] - c0 : -1, 13);
        chk("t1_issues", ev_issue_a.size(), 8);
        if (ev_issue_a.size() == 8) begin
            chk("t1_issue_first_cyc", ev_issue_c[0] - c0, 1);
            chk("t1_addr_first", ev_issue_a[0], 16'h1230);
            chk("t1_addr_last", ev_issue_a[7], 16'h123E);
        end
        chk("t1_fills", ev_fill_c.size(), 8);
        if (ev_fill_c.size() == 8) begin
            chk("t1_fill_first", ev_fill_c[0] - c0, 5);
            chk("t1_fill_last", ev_fill_c[7] - c0, 12);
        end
        chk("t1_tag_cycle", ev_tag_c.size() > 0 ? ev_tag_c[0] - c0 : -1, 12);
        settle();

        // Both channels at once
        c0 = cyc;
        miss_addr = {16'h3456, 16'h2000};
        miss_req = 2'b11;
        wait_done(1, 40);
        miss_req[0] = 1'b0;
        wait_done(2, 40);
        miss_req[1] = 1'b0;
        if (ev_done_c.size() == 2) begin
            chk("t2_first_ch", ev_done_ch[0], 0);
            chk("t2_first_cycle", ev_done_c[0] - c0, 13);
            chk("t2_second_ch", ev_done_ch[1], 1);
            chk("t2_second_cycle", ev_done_c[1] - c0, 27);
        end
        chk("t2_issues", ev_issue_a.size(), 16);
        if (ev_issue_a.size() == 16) chk("t2_ch1_base", ev_issue_a[8], 16'h3450);
        settle();

        // Short block, 32-bit words, latency 1, wrap at top of address space
        c0 = cyc;
        addr2 = 16'hFFF4;
        req2 = 1'b1;
        n = 0;
        while (ev2_done_c.size() == 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        req2 = 1'b0;
        chk("t3_done_cycle", ev2_done_c.size() > 0 ? ev2_done_c[0] - c0 : -1, 6);
        chk("t3_tag_cycle", ev2_tag_c.size() > 0 ? ev2_tag_c[0] - c0 : -1, 5);
        chk("t3_issues", ev2_issue_a.size(), 4);
        chk("t3_fills", ev2_fill_a.size(), 4);
        if (ev2_issue_a.size() == 4 && ev2_fill_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_issue_addr", ev2_issue_a[i], 16'hFFF0 + 16'(4 * i));
                chk("t3_fill_addr", ev2_fill_a[i], 16'hFFF0 + 16'(4 * i));
            end
        end
        settle();

        // Asynchronous reset in the middle of a fill
        c0 = cyc;
        miss_addr[15:0] = 16'h4A4A;
        miss_req = 2'b01;
        wait_cyc(c0 + 7);
        #1;
        rst = 1'b1;
        miss_req = 2'b00;
        #1;
        chk("t4_grant", grant, 2'b00);
        chk("t4_busy", busy, 1'b0);
        chk("t4_mem_en", mem_en, 1'b0);
        chk("t4_mem_addr", mem_addr, 16'h0000);
        chk("t4_fill_we", fill_we, 2'b00);
        chk("t4_fill_addr", fill_addr, 16'h0000);
        chk("t4_tag_we", tag_we, 2'b00);
        chk("t4_miss_done", miss_done, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("t4_stale_fills", ev_fill_c.size(), 0);
        chk("t4_stale_tags", ev_tag_c.size(), 0);
        clear_logs();
        c0 = cyc;
        miss_addr[15:0] = 16'h5678;
        miss_req = 2'b01;
        wait_done(1, 40);
        miss_req = 2'b00;
        chk("t4_after_done", ev_done_c.size() > 0 ? ev_done_c[0] - c0 : -1, 13);
        chk("t4_after_base", ev_issue_a.size() > 0 ? ev_issue_a[0] : 16'hDEAD, 16'h5670);
        chk("t4_after_fills", ev_fill_c.size(), 8);
        settle();

        // Requestor drops its miss mid-fill
        c0 = cyc;
        miss_addr[31:16] = 16'h0ABC;
        miss_req = 2'b10;
        wait_cyc(c0 + 3);
        miss_req = 2'b00;
        wait_done(1, 40);
        chk("t5_done_cycle", ev_done_c.size() > 0 ? ev_done_c[0] - c0 : -1, 13);
        chk("t5_done_ch", ev_done_ch.size() > 0 ? ev_done_ch[0] : -1, 1);
        chk("t5_base", ev_issue_a.size() > 0 ? ev_issue_a[0] : 16'hDEAD, 16'h0AB0);
        settle();

        // Random requests with stray return pulses while idle
        glitch_en = 1;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (last_done[i]) begin
                    miss_req[i] = 1'b0;
                end else if (!miss_req[i] && $urandom_range(0, 5) == 0) begin
                    miss_addr[i*AW +: AW] = AW'($urandom);
                    miss_req[i] = 1'b1;
                end
            end
        end
        glitch_en = 0;
        n = 0;
        while ((m_active || miss_req != '0) && n < 200) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (last_done[i]) miss_req[i] = 1'b0;
            end
            n++;
        end
        chk("random_drain", 32'(n < 200), 32'd1);
        chk("random_fills_seen", 32'(ev_done_c.size() > 20), 32'd1);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
